// File: rtl/ysyx_23060221_lsu_if.sv
// Bundle of every handshake and bus signal of the load/store unit.
//   upstream (execute)  : EXU_valid, LSU_ready, alu_res, st_data, mem_ren, mem_wen, funct3
//   memory bus          : mem_req, mem_gnt, mem_we, mem_addr, mem_wdata, mem_wstrb,
//                         mem_rvalid, mem_rdata
//   downstream (wb)     : LSU_valid, WBU_ready, lsres, misalign
// The slave modport is the LSU itself. The master modport is the surrounding pipeline,
// bus and writeback environment.
interface ysyx_23060221_lsu_if;
  logic        EXU_valid;
  logic        LSU_ready;
  logic [31:0] alu_res;
  logic [31:0] st_data;
  logic        mem_ren;
  logic        mem_wen;
  logic [2:0]  funct3;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        LSU_valid;
  logic        WBU_ready;
  logic [31:0] lsres;
  logic        misalign;

  modport slave (
    input  EXU_valid, alu_res, st_data, mem_ren, mem_wen, funct3,
    input  mem_gnt, mem_rvalid, mem_rdata, WBU_ready,
    output LSU_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output LSU_valid, lsres, misalign
  );

  modport master (
    output EXU_valid, alu_res, st_data, mem_ren, mem_wen, funct3,
    output mem_gnt, mem_rvalid, mem_rdata, WBU_ready,
    input  LSU_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  LSU_valid, lsres, misalign
  );
endinterface

// File: rtl/ysyx_23060221_lsu.sv
// Load/store stage between execute and writeback.
// It accepts one op per EXU_valid/LSU_ready handshake. The op is either a plain ALU result,
// a load or a store. For a load or store it runs one word-aligned bus transaction. It then
// presents the writeback value on lsres/LSU_valid until WBU_ready is seen.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : ysyx_23060221_lsu_if.slave. This carries the execute handshake, the
//              memory bus and the writeback handshake.
// Parameters: RESET_PC_UNUSED must be 0. MISALIGN_CHECK=1 turns misaligned half/word
// accesses into a bus-free completion with misalign set.
module ysyx_23060221_lsu #(
  parameter int RESET_PC_UNUSED = 0,
  parameter int MISALIGN_CHECK  = 1
) (
  input  logic               clk,
  input  logic               rst,
  ysyx_23060221_lsu_if.slave bus
);

  if (RESET_PC_UNUSED != 0) begin : g_bad_cfg
    $error("RESET_PC_UNUSED is reserved and must be 0");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] lsres_q, lsres_d;
  logic [2:0]  f3_q, f3_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic        mis_q, mis_d;
  logic        accept;

  // 0 = byte, 1 = half, 2 = word. Unused funct3 codes fall back to word.
  function automatic logic [1:0] op_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: op_size = 2'd0;
      3'b001, 3'b101: op_size = 2'd1;
      default:        op_size = 2'd2;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] o);
    case (op_size(f3))
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = o[0];
      default: is_misaligned = |o;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] o);
    case (op_size(f3))
      2'd0:    store_strb = 4'b0001 << o;
      2'd1:    store_strb = 4'b0011 << o;
      default: store_strb = 4'hF;
    endcase
  endfunction

  // The data is replicated across all lanes, so the strobes alone pick the target bytes.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (op_size(f3))
      2'd0:    store_data = {4{d[7:0]}};
      2'd1:    store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] o,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {o, 3'b000});
    h = 16'(w >> {o, 3'b000});
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b100:  load_extract = {24'd0, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = w;
    endcase
  endfunction

  assign accept = bus.EXU_valid & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    f3_d    = f3_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    lsres_d = lsres_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = bus.alu_res;
          sdata_d = bus.st_data;
          f3_d    = bus.funct3;
          ren_d   = bus.mem_ren;
          wen_d   = bus.mem_wen;
          mis_d   = 1'b0;
          if (!(bus.mem_ren | bus.mem_wen)) begin
            state_d = DONE;
            lsres_d = bus.alu_res;
          end else if ((MISALIGN_CHECK != 0) && is_misaligned(bus.funct3, bus.alu_res[1:0])) begin
            state_d = DONE;
            lsres_d = 32'd0;
            mis_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          if (bus.mem_rvalid) begin
            // The grant and the response arrive in the same cycle, so WAIT is skipped.
            state_d = DONE;
            lsres_d = ren_q ? load_extract(f3_q, addr_q[1:0], bus.mem_rdata) : 32'd0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = DONE;
          lsres_d = ren_q ? load_extract(f3_q, addr_q[1:0], bus.mem_rdata) : 32'd0;
        end
      end
      DONE: begin
        if (bus.WBU_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      sdata_q <= 32'd0;
      f3_q    <= 3'd0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      lsres_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      f3_q    <= f3_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      lsres_q <= lsres_d;
      mis_q   <= mis_d;
    end
  end

  // All bus and writeback outputs come from registered state only, so they stay
  // stable while a request or a result is held.
  assign bus.LSU_ready = (state_q == IDLE);
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = wen_q;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = store_data(f3_q, sdata_q);
  assign bus.mem_wstrb = wen_q ? store_strb(f3_q, addr_q[1:0]) : 4'b0000;
  assign bus.LSU_valid = (state_q == DONE);
  assign bus.lsres     = lsres_q;
  assign bus.misalign  = mis_q;

endmodule

// File: tb/tb_ysyx_23060221_lsu.sv
// Self-checking bench for the load/store unit. It uses a scoreboard of expected
// writeback results.
module tb_ysyx_23060221_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060221_lsu_if bus ();

  ysyx_23060221_lsu #(.RESET_PC_UNUSED(0), .MISALIGN_CHECK(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [31:0] lsres;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int vectors = 0;
  int miscompares = 0;

  logic        o_ready_at_issue, o_req_seen, o_unstable, o_timeout;
  logic        o_ready_after, o_valid_after, o_we, o_mis;
  logic [31:0] o_addr, o_wdata, o_lsres;
  logic [3:0]  o_wstrb;
  int          o_lat;

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] o,
                                             input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = (o == 2'd0) ? w[7:0] : (o == 2'd1) ? w[15:8] : (o == 2'd2) ? w[23:16] : w[31:24];
    h = o[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Issues one op and acts as the bus, then records what the DUT did.
  // Before the grant it pulses spurious responses, and after the grant spurious grants.
  // The DUT must ignore both. The task starts and ends on a falling edge.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] sd, input logic ren,
                        input logic wen, input logic [2:0] f3, input int gnt_dly,
                        input int rv_dly, input logic [31:0] rd);
    int cyc, reqc, waitc;
    logic granted;
    o_req_seen = 1'b0; o_unstable = 1'b0; o_timeout = 1'b1;
    o_ready_after = 1'b0; o_valid_after = 1'b1;
    o_addr = '0; o_wdata = '0; o_wstrb = '0; o_we = 1'b0;
    o_ready_at_issue = bus.LSU_ready;
    bus.EXU_valid = 1'b1; bus.alu_res = alu; bus.st_data = sd;
    bus.mem_ren = ren; bus.mem_wen = wen; bus.funct3 = f3;
    @(posedge clk); @(negedge clk);
    bus.EXU_valid = 1'b0; bus.alu_res = ~alu; bus.st_data = ~sd;
    bus.mem_ren = 1'b0; bus.mem_wen = 1'b0; bus.funct3 = ~f3;
    cyc = 0; reqc = 0; waitc = 0; granted = 1'b0;
    while (cyc < 200) begin
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
      if (bus.LSU_valid) begin
        o_timeout = 1'b0;
        break;
      end
      if (bus.mem_req) begin
        if (granted) o_unstable = 1'b1;
        if (!o_req_seen) begin
          o_addr = bus.mem_addr; o_wdata = bus.mem_wdata;
          o_wstrb = bus.mem_wstrb; o_we = bus.mem_we;
        end else if (o_addr !== bus.mem_addr || o_wdata !== bus.mem_wdata ||
                     o_wstrb !== bus.mem_wstrb || o_we !== bus.mem_we) begin
          o_unstable = 1'b1;
        end
        o_req_seen = 1'b1;
        reqc++;
        if (reqc > gnt_dly) begin
          bus.mem_gnt = 1'b1; granted = 1'b1;
          if (rv_dly == 0) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = rd; end
        end else begin
          bus.mem_rvalid = 1'b1; bus.mem_rdata = ~rd;
        end
      end else if (granted) begin
        waitc++;
        bus.mem_gnt = 1'b1;
        if (waitc >= rv_dly) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = rd; end
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    o_lat = cyc; o_lsres = bus.lsres; o_mis = bus.misalign;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    if (o_timeout) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0;
    end else if (bus.WBU_ready) begin
      @(posedge clk); @(negedge clk);
      o_ready_after = bus.LSU_ready; o_valid_after = bus.LSU_valid;
    end
  endtask

  task automatic test_reset();
    bus.EXU_valid = 1'b0; bus.alu_res = '0; bus.st_data = '0; bus.mem_ren = 1'b0;
    bus.mem_wen = 1'b0; bus.funct3 = '0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0; bus.WBU_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.LSU_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.LSU_ready); end
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
    vectors++; if (bus.LSU_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.LSU_valid); end
    vectors++; if (bus.lsres !== 32'd0) begin miscompares++; $display("FAIL reset_lsres: got %h want 0", bus.lsres); end
    vectors++; if (bus.misalign !== 1'b0) begin miscompares++; $display("FAIL reset_misalign: got %b want 0", bus.misalign); end
  endtask

  task automatic test_nonmem();
    sb_q.push_back('{lsres: 32'h1234_5678, mis: 1'b0});
    run_op(32'h1234_5678, 32'h0, 1'b0, 1'b0, 3'b010, 0, 0, 32'h0);
    e = sb_q.pop_front();
    vectors++; if (o_timeout !== 1'b0) begin miscompares++; $display("FAIL nonmem_timeout: got %b want 0", o_timeout); end
    vectors++; if (o_ready_at_issue !== 1'b1) begin miscompares++; $display("FAIL nonmem_ready_issue: got %b want 1", o_ready_at_issue); end
    vectors++; if (o_lsres !== e.lsres) begin miscompares++; $display("FAIL nonmem_lsres: got %h want %h", o_lsres, e.lsres); end
    vectors++; if (o_mis !== e.mis) begin miscompares++; $display("FAIL nonmem_misalign: got %b want %b", o_mis, e.mis); end
    vectors++; if (o_lat !== 0) begin miscompares++; $display("FAIL nonmem_latency: got %0d want 0", o_lat); end
    vectors++; if (o_req_seen !== 1'b0) begin miscompares++; $display("FAIL nonmem_req: got %b want 0", o_req_seen); end
    vectors++; if (o_ready_after !== 1'b1 || o_valid_after !== 1'b0) begin miscompares++;
      $display("FAIL nonmem_release: got ready=%b valid=%b want ready=1 valid=0", o_ready_after, o_valid_after); end
  endtask

  task automatic test_load();
    logic [31:0] ta[7] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0000,
                           32'h8000_0004, 32'h8000_0001, 32'h8000_0008};
    logic [2:0]  tf[7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b111};
    logic [31:0] tr[7] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h1234_ABCD,
                           32'hDEAD_BEEF, 32'h0000_7F00, 32'hCAFE_F00D};
    logic [31:0] tx[7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_ABCD,
                           32'hDEAD_BEEF, 32'h0000_007F, 32'hCAFE_F00D};
    int          tg[7] = '{2, 2, 1, 0, 0, 3, 1};
    int          tv[7] = '{3, 3, 1, 2, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back('{lsres: tx[i], mis: 1'b0});
      run_op(ta[i], 32'h5555_AAAA, 1'b1, 1'b0, tf[i], tg[i], tv[i], tr[i]);
      e = sb_q.pop_front();
      vectors++; if (o_timeout !== 1'b0) begin miscompares++; $display("FAIL load%0d_timeout: got %b want 0", i, o_timeout); end
      vectors++; if (o_lsres !== e.lsres) begin miscompares++; $display("FAIL load%0d_lsres: got %h want %h", i, o_lsres, e.lsres); end
      vectors++; if (o_mis !== e.mis) begin miscompares++; $display("FAIL load%0d_misalign: got %b want 0", i, o_mis); end
      vectors++; if (o_addr !== {ta[i][31:2], 2'b00}) begin miscompares++; $display("FAIL load%0d_addr: got %h want %h", i, o_addr, {ta[i][31:2], 2'b00}); end
      vectors++; if (o_wstrb !== 4'b0000 || o_we !== 1'b0) begin miscompares++; $display("FAIL load%0d_rd: got wstrb=%b we=%b want 0000/0", i, o_wstrb, o_we); end
      vectors++; if (o_req_seen !== 1'b1 || o_unstable !== 1'b0) begin miscompares++;
        $display("FAIL load%0d_req: got seen=%b unstable=%b want 1/0", i, o_req_seen, o_unstable); end
    end
  endtask

  task automatic test_store();
    logic [31:0] ta[3] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0004};
    logic [2:0]  tf[3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] td[3] = '{32'hAAAA_BEEF, 32'h1234_56A5, 32'h0102_0304};
    logic [31:0] tw[3] = '{32'hBEEF_BEEF, 32'hA5A5_A5A5, 32'h0102_0304};
    logic [3:0]  ts[3] = '{4'b1100, 4'b0010, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{lsres: 32'd0, mis: 1'b0});
      run_op(ta[i], td[i], 1'b0, 1'b1, tf[i], i, 2 - i, 32'hFFFF_FFFF);
      e = sb_q.pop_front();
      vectors++; if (o_timeout !== 1'b0) begin miscompares++; $display("FAIL store%0d_timeout: got %b want 0", i, o_timeout); end
      vectors++; if (o_lsres !== e.lsres) begin miscompares++; $display("FAIL store%0d_lsres: got %h want %h", i, o_lsres, e.lsres); end
      vectors++; if (o_wstrb !== ts[i]) begin miscompares++; $display("FAIL store%0d_wstrb: got %b want %b", i, o_wstrb, ts[i]); end
      vectors++; if (o_wdata !== tw[i]) begin miscompares++; $display("FAIL store%0d_wdata: got %h want %h", i, o_wdata, tw[i]); end
      vectors++; if (o_we !== 1'b1) begin miscompares++; $display("FAIL store%0d_we: got %b want 1", i, o_we); end
      vectors++; if (o_addr !== {ta[i][31:2], 2'b00}) begin miscompares++; $display("FAIL store%0d_addr: got %h want %h", i, o_addr, {ta[i][31:2], 2'b00}); end
      vectors++; if (o_unstable !== 1'b0) begin miscompares++; $display("FAIL store%0d_stable: got unstable=%b want 0", i, o_unstable); end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] ta[4] = '{32'h8000_0006, 32'h8000_0001, 32'h8000_0003, 32'h8000_0005};
    logic [2:0]  tf[4] = '{3'b010, 3'b001, 3'b101, 3'b010};
    logic        tw[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{lsres: 32'd0, mis: 1'b1});
      run_op(ta[i], 32'h7777_7777, ~tw[i], tw[i], tf[i], 0, 0, 32'h1111_1111);
      e = sb_q.pop_front();
      vectors++; if (o_timeout !== 1'b0) begin miscompares++; $display("FAIL mis%0d_timeout: got %b want 0", i, o_timeout); end
      vectors++; if (o_mis !== e.mis) begin miscompares++; $display("FAIL mis%0d_flag: got %b want 1", i, o_mis); end
      vectors++; if (o_lsres !== e.lsres) begin miscompares++; $display("FAIL mis%0d_lsres: got %h want 0", i, o_lsres); end
      vectors++; if (o_req_seen !== 1'b0) begin miscompares++; $display("FAIL mis%0d_req: got %b want 0", i, o_req_seen); end
      vectors++; if (o_lat !== 0) begin miscompares++; $display("FAIL mis%0d_latency: got %0d want 0", i, o_lat); end
    end
  endtask

  task automatic test_backpressure();
    bus.WBU_ready = 1'b0;
    sb_q.push_back('{lsres: 32'hCAFE_0001, mis: 1'b0});
    run_op(32'hCAFE_0001, 32'h0, 1'b0, 1'b0, 3'b000, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      bus.EXU_valid = 1'b1; bus.alu_res = 32'h0BAD_0BAD; bus.mem_ren = 1'b0; bus.mem_wen = 1'b0;
      @(posedge clk); @(negedge clk);
      vectors++; if (bus.LSU_valid !== 1'b1) begin miscompares++; $display("FAIL bp%0d_valid: got %b want 1", i, bus.LSU_valid); end
      vectors++; if (bus.lsres !== 32'hCAFE_0001) begin miscompares++; $display("FAIL bp%0d_lsres: got %h want cafe0001", i, bus.lsres); end
      vectors++; if (bus.LSU_ready !== 1'b0) begin miscompares++; $display("FAIL bp%0d_ready: got %b want 0", i, bus.LSU_ready); end
    end
    bus.EXU_valid = 1'b0; bus.WBU_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    e = sb_q.pop_front();
    vectors++; if (o_lsres !== e.lsres) begin miscompares++; $display("FAIL bp_lsres: got %h want %h", o_lsres, e.lsres); end
    vectors++; if (bus.LSU_ready !== 1'b1 || bus.LSU_valid !== 1'b0) begin miscompares++;
      $display("FAIL bp_release: got ready=%b valid=%b want 1/0", bus.LSU_ready, bus.LSU_valid); end
    sb_q.push_back('{lsres: 32'h0000_BEEF, mis: 1'b0});
    run_op(32'h0000_BEEF, 32'h0, 1'b0, 1'b0, 3'b000, 0, 0, 32'h0);
    e = sb_q.pop_front();
    vectors++; if (o_lsres !== e.lsres) begin miscompares++; $display("FAIL bp_next_lsres: got %h want %h", o_lsres, e.lsres); end
  endtask

  task automatic test_reset_midop();
    logic bad;
    // Reset during REQ
    bus.EXU_valid = 1'b1; bus.alu_res = 32'h8000_0010; bus.mem_ren = 1'b1; bus.funct3 = 3'b010;
    @(posedge clk); @(negedge clk);
    bus.EXU_valid = 1'b0; bus.mem_ren = 1'b0;
    vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL rst_req_pre: got %b want 1", bus.mem_req); end
    rst = 1'b1; #1;
    vectors++; if (bus.mem_req !== 1'b0 || bus.LSU_ready !== 1'b1) begin miscompares++;
      $display("FAIL rst_req_drop: got req=%b ready=%b want 0/1", bus.mem_req, bus.LSU_ready); end
    @(negedge clk); rst = 1'b0;
    // Reset during WAIT, followed by a stale response
    bus.EXU_valid = 1'b1; bus.mem_ren = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.EXU_valid = 1'b0; bus.mem_ren = 1'b0; bus.mem_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.mem_gnt = 1'b0;
    rst = 1'b1; #1;
    vectors++; if (bus.LSU_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.LSU_ready !== 1'b1) begin miscompares++;
      $display("FAIL rst_wait: got valid=%b req=%b ready=%b want 0/0/1", bus.LSU_valid, bus.mem_req, bus.LSU_ready); end
    @(negedge clk); rst = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    @(posedge clk); @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.LSU_valid !== 1'b0 || bus.mem_req !== 1'b0) bad = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL rst_stale_rvalid: got spurious activity=%b want 0", bad); end
    // Reset while holding a result in DONE
    bus.WBU_ready = 1'b0;
    run_op(32'h00C0_FFEE, 32'h0, 1'b0, 1'b0, 3'b000, 0, 0, 32'h0);
    rst = 1'b1; #1;
    vectors++; if (bus.LSU_valid !== 1'b0 || bus.lsres !== 32'd0) begin miscompares++;
      $display("FAIL rst_done: got valid=%b lsres=%h want 0/0", bus.LSU_valid, bus.lsres); end
    @(negedge clk); rst = 1'b0; bus.WBU_ready = 1'b1;
    sb_q.push_back('{lsres: 32'h0000_00AB, mis: 1'b0});
    run_op(32'h8000_0011, 32'h0, 1'b1, 1'b0, 3'b100, 1, 1, 32'h0000_AB00);
    e = sb_q.pop_front();
    vectors++; if (o_timeout !== 1'b0 || o_lsres !== e.lsres) begin miscompares++;
      $display("FAIL rst_next_op: got timeout=%b lsres=%h want 0/%h", o_timeout, o_lsres, e.lsres); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  fsel[6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
    logic [31:0] a, rd, exp_addr;
    logic [2:0]  f3;
    logic        mem;
    for (int i = 0; i < 12; i++) begin
      mem = ($urandom_range(0, 3) != 0);
      f3 = fsel[$urandom_range(0, 5)];
      rd = $urandom;
      a = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      if (f3 == 3'b001 || f3 == 3'b101) a[0] = 1'b0;
      else if (f3 != 3'b000 && f3 != 3'b100) a[1:0] = 2'b00;
      exp_addr = {a[31:2], 2'b00};
      sb_q.push_back('{lsres: mem ? model_load(rd, a[1:0], f3) : a, mis: 1'b0});
      run_op(a, $urandom, mem, 1'b0, f3, $urandom_range(0, 2), $urandom_range(0, 2), rd);
      e = sb_q.pop_front();
      vectors++; if (o_timeout !== 1'b0) begin miscompares++; $display("FAIL b2b%0d_timeout: got %b want 0", i, o_timeout); end
      vectors++; if (o_lsres !== e.lsres || o_mis !== e.mis) begin miscompares++;
        $display("FAIL b2b%0d_result: got %h/%b want %h/%b", i, o_lsres, o_mis, e.lsres, e.mis); end
      vectors++; if (o_req_seen !== mem || (mem && o_addr !== exp_addr)) begin miscompares++;
        $display("FAIL b2b%0d_bus: got req=%b addr=%h want req=%b addr=%h", i, o_req_seen, o_addr, mem, exp_addr); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_misalign();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
